// File: rtl/wb_stage.sv
// wb_stage: write-back stage with a single outstanding data-memory load.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   ex_valid/ex_ready handshake from execute; flush drops the offered instruction
//   ex_alu_result     ALU result, or the load address for loads
//   ex_pc, ex_imm     sources for the PC+4 and immediate write-back selections
//   ex_rd, ex_regwrite, ex_wbsel, ex_funct3  destination, write enable, source select, load type
//   dmem_req/addr     one-cycle load request with word-aligned address
//   dmem_rdata/rvalid load response
//   rfwrite/waddr/wdata  register-file write port (registered, one cycle per write)
//   ld_pending/ld_pending_rd  load in flight and its destination register
//   load_fault        one-cycle pulse on misaligned/illegal load or response timeout
//
// state     | meaning
// IDLE      | ready to accept; non-loads retire the cycle after accept
// LOAD_WAIT | load issued, waiting for dmem_rvalid or timeout
module wb_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        flush,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [4:0]  ex_rd,
  input  logic        ex_regwrite,
  input  logic [1:0]  ex_wbsel,
  input  logic [2:0]  ex_funct3,
  output logic        dmem_req,
  output logic [31:0] dmem_addr,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_rvalid,
  output logic        rfwrite,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        ld_pending,
  output logic [4:0]  ld_pending_rd,
  output logic        load_fault
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [4:0]    ld_rd;
  logic [2:0]    ld_f3;
  logic [1:0]    ld_off;
  logic          ld_we;

  logic          accept, is_load, misalign, ld_issue, ld_done, ld_tmo;
  logic [31:0]   wb_val, ld_shift, ld_data;

  assign ex_ready      = (state == IDLE);
  assign accept        = ex_valid & ex_ready & ~flush;
  assign is_load       = (ex_wbsel == 2'b01);
  assign ld_issue      = accept & is_load & ~misalign;
  assign ld_done       = (state == LOAD_WAIT) & dmem_rvalid;
  // Timeout fires on the last allowed wait cycle; a response in that same cycle wins.
  assign ld_tmo        = (state == LOAD_WAIT) & ~dmem_rvalid & (cnt == CW'(TIMEOUT - 1));
  assign ld_pending    = (state == LOAD_WAIT);
  assign ld_pending_rd = ld_pending ? ld_rd : 5'd0;

  always_comb begin
    misalign = 1'b0;
    case (ex_funct3)
      3'b000, 3'b100: misalign = 1'b0;
      3'b001, 3'b101: misalign = ex_alu_result[0];
      3'b010:         misalign = (ex_alu_result[1:0] != 2'b00);
      default:        misalign = 1'b1;
    endcase
  end

  always_comb begin
    wb_val = ex_alu_result;
    case (ex_wbsel)
      2'b10:   wb_val = ex_pc + 32'd4;
      2'b11:   wb_val = ex_imm;
      default: wb_val = ex_alu_result;
    endcase
  end

  // Aligned accesses only reach here, so shifting by the byte offset puts the
  // selected byte or halfword at bit 0 in every case.
  always_comb begin
    ld_shift = dmem_rdata >> {ld_off, 3'b000};
    ld_data  = dmem_rdata;
    case (ld_f3)
      3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      3'b100:  ld_data = {24'd0, ld_shift[7:0]};
      3'b101:  ld_data = {16'd0, ld_shift[15:0]};
      default: ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (ld_issue) state_nx = LOAD_WAIT;
      LOAD_WAIT: if (ld_done || ld_tmo) state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      rfwrite    <= 1'b0;
      waddr      <= 5'd0;
      wdata      <= 32'd0;
      dmem_req   <= 1'b0;
      dmem_addr  <= 32'd0;
      load_fault <= 1'b0;
      ld_rd      <= 5'd0;
      ld_f3      <= 3'd0;
      ld_off     <= 2'd0;
      ld_we      <= 1'b0;
    end else begin
      rfwrite    <= 1'b0;
      dmem_req   <= 1'b0;
      load_fault <= 1'b0;

      if (ld_issue)                cnt <= '0;
      else if (state == LOAD_WAIT) cnt <= cnt + CW'(1);

      if (accept) begin
        if (!is_load) begin
          rfwrite <= ex_regwrite & (ex_rd != 5'd0);
          waddr   <= ex_rd;
          wdata   <= wb_val;
        end else if (misalign) begin
          load_fault <= 1'b1;
        end else begin
          dmem_req  <= 1'b1;
          dmem_addr <= {ex_alu_result[31:2], 2'b00};
          ld_rd     <= ex_rd;
          ld_f3     <= ex_funct3;
          ld_off    <= ex_alu_result[1:0];
          ld_we     <= ex_regwrite;
        end
      end

      if (ld_done) begin
        rfwrite <= ld_we & (ld_rd != 5'd0);
        waddr   <= ld_rd;
        wdata   <= ld_data;
      end

      if (ld_tmo) load_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, flush;
  logic [31:0] ex_alu_result, ex_pc, ex_imm;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic [1:0]  ex_wbsel;
  logic [2:0]  ex_funct3;
  logic        dmem_req;
  logic [31:0] dmem_addr, dmem_rdata;
  logic        dmem_rvalid;
  logic        rfwrite;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        ld_pending;
  logic [4:0]  ld_pending_rd;
  logic        load_fault;

  int n_chk = 0;
  int n_err = 0;

  wb_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready), .flush(flush),
    .ex_alu_result(ex_alu_result), .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_wbsel(ex_wbsel), .ex_funct3(ex_funct3),
    .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
    .dmem_rvalid(dmem_rvalid), .rfwrite(rfwrite), .waddr(waddr), .wdata(wdata),
    .ld_pending(ld_pending), .ld_pending_rd(ld_pending_rd), .load_fault(load_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [1:0] wbsel, input logic [2:0] f3, input logic [4:0] rd,
                    input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] imm,
                    input logic we);
    ex_valid      = 1'b1;
    ex_wbsel      = wbsel;
    ex_funct3     = f3;
    ex_rd         = rd;
    ex_alu_result = alu;
    ex_pc         = pc;
    ex_imm        = imm;
    ex_regwrite   = we;
  endtask

  initial begin
    rst = 1'b1; ex_valid = 1'b0; flush = 1'b0; ex_alu_result = 0; ex_pc = 0; ex_imm = 0;
    ex_rd = 0; ex_regwrite = 0; ex_wbsel = 0; ex_funct3 = 0; dmem_rdata = 0; dmem_rvalid = 0;
    tick(); tick();
    chk("rst_ready", ex_ready, 1);
    chk("rst_rfwrite", rfwrite, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_pending", ld_pending, 0);
    chk("rst_fault", load_fault, 0);
    rst = 1'b0;
    tick();

    // flush in IDLE: nothing captured
    op(2'b00, 3'd0, 5'd3, 32'hAAAA_0000, 0, 0, 1'b1); flush = 1'b1;
    tick();
    chk("flush_rfwrite", rfwrite, 0);
    chk("flush_waddr", waddr, 0);
    flush = 1'b0; ex_valid = 1'b0;

    // ALU write
    op(2'b00, 3'd0, 5'd5, 32'h0000_1234, 0, 0, 1'b1);
    tick();
    chk("alu_rfwrite", rfwrite, 1);
    chk("alu_waddr", waddr, 5);
    chk("alu_wdata", wdata, 32'h0000_1234);
    // back-to-back: IMM then ALU with regwrite=0
    op(2'b11, 3'd0, 5'd7, 32'h0, 0, 32'hDEAD_BEEF, 1'b1);
    tick();
    chk("imm_rfwrite", rfwrite, 1);
    chk("imm_waddr", waddr, 7);
    chk("imm_wdata", wdata, 32'hDEAD_BEEF);
    op(2'b00, 3'd0, 5'd8, 32'h0000_0055, 0, 0, 1'b0);
    tick();
    chk("nowe_rfwrite", rfwrite, 0);
    chk("nowe_wdata", wdata, 32'h0000_0055);
    ex_valid = 1'b0;
    tick();
    chk("idle_rfwrite", rfwrite, 0);

    // JAL with PC wrap, then rd=0
    op(2'b10, 3'd0, 5'd1, 0, 32'hFFFF_FFFC, 0, 1'b1);
    tick();
    chk("jal_rfwrite", rfwrite, 1);
    chk("jal_wdata", wdata, 32'h0000_0000);
    op(2'b10, 3'd0, 5'd0, 0, 32'h0000_1000, 0, 1'b1);
    tick();
    chk("jal_rd0_rfwrite", rfwrite, 0);
    chk("jal_rd0_wdata", wdata, 32'h0000_1004);
    ex_valid = 1'b0;

    // LB addr 0x103, response 3 cycles after request, flush offered during the wait
    op(2'b01, 3'b000, 5'd6, 32'h0000_0103, 0, 0, 1'b1);
    tick();
    ex_valid = 1'b0;
    chk("lb_req", dmem_req, 1);
    chk("lb_addr", dmem_addr, 32'h0000_0100);
    chk("lb_ready", ex_ready, 0);
    chk("lb_pending", ld_pending, 1);
    chk("lb_pending_rd", ld_pending_rd, 6);
    op(2'b00, 3'd0, 5'd9, 32'h1111_1111, 0, 0, 1'b1); flush = 1'b1;
    tick();
    chk("lb_req_pulse", dmem_req, 0);
    chk("lb_wait_ready", ex_ready, 0);
    chk("lb_wait_rfwrite", rfwrite, 0);
    tick();
    chk("lb_flush_noeffect", ld_pending, 1);
    ex_valid = 1'b0; flush = 1'b0;
    tick();
    chk("lb_wait_ready3", ex_ready, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h80FF_0000;
    tick();
    dmem_rvalid = 1'b0;
    chk("lb_rfwrite", rfwrite, 1);
    chk("lb_waddr", waddr, 6);
    chk("lb_wdata", wdata, 32'hFFFF_FF80);
    chk("lb_ready_after", ex_ready, 1);
    chk("lb_pending_after", ld_pending_rd, 0);

    // LHU 0x102, earliest response
    op(2'b01, 3'b101, 5'd9, 32'h0000_0102, 0, 0, 1'b1);
    tick();
    ex_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'hBEEF_0001;
    tick();
    dmem_rvalid = 1'b0;
    chk("lhu_rfwrite", rfwrite, 1);
    chk("lhu_wdata", wdata, 32'h0000_BEEF);

    // LH 0x0, sign-extended low half
    op(2'b01, 3'b001, 5'd4, 32'h0000_0000, 0, 0, 1'b1);
    tick();
    ex_valid = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_8001;
    tick();
    dmem_rvalid = 1'b0;
    chk("lh_wdata", wdata, 32'hFFFF_8001);

    // misaligned LW and illegal funct3
    op(2'b01, 3'b010, 5'd2, 32'h0000_0102, 0, 0, 1'b1);
    tick();
    ex_valid = 1'b0;
    chk("lw_mis_fault", load_fault, 1);
    chk("lw_mis_req", dmem_req, 0);
    chk("lw_mis_rfwrite", rfwrite, 0);
    chk("lw_mis_ready", ex_ready, 1);
    tick();
    chk("lw_mis_pulse", load_fault, 0);
    op(2'b01, 3'b011, 5'd2, 32'h0000_0100, 0, 0, 1'b1);
    tick();
    ex_valid = 1'b0;
    chk("f3_011_fault", load_fault, 1);
    chk("f3_011_pending", ld_pending, 0);

    // timeout: no response for 16 wait cycles, late rvalid ignored
    op(2'b01, 3'b010, 5'd10, 32'h0000_0200, 0, 0, 1'b1);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("tmo_still_wait", ld_pending, 1);
    chk("tmo_no_early_fault", load_fault, 0);
    tick();
    chk("tmo_fault", load_fault, 1);
    chk("tmo_rfwrite", rfwrite, 0);
    chk("tmo_ready", ex_ready, 1);
    dmem_rvalid = 1'b1; dmem_rdata = 32'h0BAD_0BAD;
    tick();
    dmem_rvalid = 1'b0;
    chk("tmo_pulse", load_fault, 0);
    chk("tmo_late_rvalid", rfwrite, 0);

    // rvalid on the last wait cycle wins over timeout
    op(2'b01, 3'b010, 5'd11, 32'h0000_0300, 0, 0, 1'b1);
    tick();
    ex_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    tick();
    dmem_rvalid = 1'b0;
    chk("edge_rfwrite", rfwrite, 1);
    chk("edge_wdata", wdata, 32'hCAFE_F00D);
    chk("edge_nofault", load_fault, 0);

    // reset mid-wait abandons the load
    op(2'b01, 3'b010, 5'd12, 32'h0000_0400, 0, 0, 1'b1);
    tick();
    ex_valid = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("rstw_pending", ld_pending, 0);
    chk("rstw_ready", ex_ready, 1);
    tick();
    rst = 1'b0;
    dmem_rvalid = 1'b1; dmem_rdata = 32'h7777_7777;
    tick();
    dmem_rvalid = 1'b0;
    chk("rstw_rfwrite", rfwrite, 0);
    chk("rstw_pending2", ld_pending, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL use a single clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 The block SHALL have parameter TIMEOUT, default 16: the maximum number of cycles spent in LOAD_WAIT before a fault is raised.
REQ-003 The block SHALL have these ports, one per line (name  direction  width  meaning):
- clk  in  1  clock, rising-edge active
- rst  in  1  asynchronous active-high reset
- ex_valid  in  1  execute presents an instruction
- ex_ready  out  1  stage can accept
- flush  in  1  discard the offered instruction this cycle
- ex_alu_result  in  32  ALU result / load address
- ex_pc  in  32  instruction PC
- ex_imm  in  32  U-type immediate
- ex_rd  in  5  destination register
- ex_regwrite  in  1  instruction writes rd
- ex_wbsel  in  2  00 ALU, 01 MEM, 10 PC+4, 11 IMM
- ex_funct3  in  3  load type
- dmem_req  out  1  load request pulse
- dmem_addr  out  32  word-aligned load address
- dmem_rdata  in  32  load data
- dmem_rvalid  in  1  load data valid
- rfwrite  out  1  register-file write enable
- waddr  out  5  register-file write address
- wdata  out  32  register-file write data
- ld_pending  out  1  load outstanding
- ld_pending_rd  out  5  rd of the outstanding load
- load_fault  out  1  one-cycle fault pulse

Function
REQ-004 FSM states SHALL be IDLE and LOAD_WAIT; ex_ready SHALL equal (state==IDLE).
REQ-005 Accept SHALL occur on a rising edge when ex_valid & ex_ready & !flush; there SHALL be no capture when flush=1.
REQ-006 Accepted non-load (wbsel!=01): rfwrite, waddr and wdata SHALL be registered and valid for exactly the next cycle, so back-to-back accepts give one write per cycle.
REQ-007 wdata SHALL be selected as: ALU → ex_alu_result; PC+4 → ex_pc+4 (mod 2^32); IMM → ex_imm.
REQ-008 rfwrite SHALL be 1 only if the instruction is accepted, ex_regwrite=1 and rd!=0; otherwise rfwrite=0, and waddr/wdata SHALL still update.
REQ-009 Accepted load: dmem_req SHALL pulse 1 in the next cycle, with dmem_addr = {addr[31:2],2'b00}, and the state SHALL go to LOAD_WAIT.
REQ-010 The captured rd, funct3 and addr[1:0] SHALL be held in LOAD_WAIT.
REQ-011 In LOAD_WAIT the block SHALL set ld_pending=1 and ld_pending_rd = the captured rd; otherwise ld_pending=0 and ld_pending_rd=0.
REQ-012 dmem_rvalid sampled 1 in LOAD_WAIT SHALL cause: next cycle rfwrite per REQ-008, wdata = extracted data, and state → IDLE.
REQ-013 The earliest load write SHALL be 2 cycles after accept.
REQ-014 Load extraction SHALL use the byte/half selected by addr[1:0]:
- 000 LB sign-extend
- 001 LH sign-extend
- 010 LW
- 100 LBU zero-extend
- 101 LHU zero-extend
REQ-015 A misaligned load (LH/LHU with addr[0]=1, LW with addr[1:0]!=0) or funct3 in {011,110,111} SHALL raise load_fault for 1 cycle after accept, issue no dmem_req, write nothing, and stay in IDLE.
REQ-016 A cycle counter SHALL clear on entry to LOAD_WAIT and increment each LOAD_WAIT cycle.
REQ-017 If the counter reaches TIMEOUT with no rvalid, load_fault SHALL pulse 1 cycle, there SHALL be no write, and the state SHALL return to IDLE.
REQ-018 dmem_rvalid SHALL be ignored when in IDLE.
REQ-019 If rvalid arrives in the same cycle the counter reaches TIMEOUT, rvalid SHALL win (normal write, no fault).
REQ-020 flush SHALL have no effect in LOAD_WAIT: a committed load SHALL complete.
REQ-021 rfwrite and load_fault SHALL never both be 1 in the same cycle.

Reset
REQ-022 While rst=1, independent of clk: state=IDLE, counter=0, and all outputs 0 except ex_ready=1.
REQ-023 rst asserted in LOAD_WAIT SHALL abandon the load; a later dmem_rvalid SHALL produce no write.

Verification
REQ-024 ALU op, rd=5, result 0x0000_1234, wbsel=00 accepted → next cycle rfwrite=1, waddr=5, wdata=0x0000_1234.
REQ-025 LB addr 0x103, dmem_rdata=0x80FF_0000, rvalid 3 cycles after dmem_req → dmem_addr=0x100; wdata=0xFFFF_FF80 one cycle after rvalid; ex_ready=0 throughout the wait.
REQ-026 LHU addr 0x102, rdata 0xBEEF_0001 → wdata=0x0000_BEEF; LW addr 0x102 → load_fault pulse, no dmem_req, no write.
REQ-027 Load with no rvalid for TIMEOUT=16 cycles → single load_fault pulse, rfwrite=0, ex_ready=1 after; a late rvalid is ignored.
REQ-028 JAL-type op, pc 0xFFFF_FFFC, wbsel=10, rd=1 → wdata=0x0000_0000; same op with rd=0 → rfwrite=0.
REQ-029 rst mid-LOAD_WAIT, then rvalid → no write, ld_pending=0; flush with ex_valid in IDLE → no capture, rfwrite=0 next cycle.
